rob_multi_commit: RTL
=====================

// Module: rob_multi_commit
// PURPOSE
//  Parametrised in-order-commit reorder buffer with multi-port CDB writeback and multi-entry commit.
//  Dispatch allocates one entry per cycle; execution units write back by ROB index; up to COMMIT_W done entries retire per cycle.
//  Register and store retirement go to the regfile and memory stage. A taken branch squashes younger entries and issues a PC redirect.
// PARAMETERS
//  DEPTH      16  entries; power of 2, >=4
//  IDX_W      4   log2(DEPTH)
//  WORD_SIZE  32  data/address width
//  REG_INDEX  5   register-number width
//  WB_PORTS   2   CDB writeback ports
//  COMMIT_W   2   max retirements per cycle
// PORTS
//  clk            in   1                   rising-edge clock
//  reset_n        in   1                   synchronous, active-low reset
//  alloc_valid    in   1                   dispatch request
//  alloc_ready    out  1                   (count<DEPTH) && !squash_now
//  alloc_rdest    in   REG_INDEX           destination register
//  alloc_to_mem   in   1                   entry is a store
//  alloc_branch   in   1                   entry is a branch
//  alloc_idx      out  IDX_W               index granted (= tail); valid when alloc_valid&&alloc_ready
//  wb_valid       in   WB_PORTS            per-port writeback strobe
//  wb_idx         in   WB_PORTS*IDX_W      target entry per port
//  wb_data        in   WB_PORTS*WORD_SIZE  result; for a branch, bit0=taken
//  wb_addr        in   WB_PORTS*WORD_SIZE  store address / branch target
//  commit_valid   out  COMMIT_W            registered retire strobes; slot0 = oldest
//  commit_to_mem  out  COMMIT_W            slot retires a store
//  commit_rdest   out  COMMIT_W*REG_INDEX  destination register
//  commit_data    out  COMMIT_W*WORD_SIZE  result / store data
//  commit_addr    out  COMMIT_W*WORD_SIZE  store address
//  mem_ready      in   1                   memory accepts a store this cycle
//  redirect_valid out  1                   one-cycle pulse on a taken-branch squash
//  redirect_pc    out  WORD_SIZE           branch target
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): head=tail=count=0; all valid/done bits cleared; every output 0 the following cycle.
//    Reset overrides all other same-edge activity, including mid-squash or mid-commit.
//  - Alloc: when alloc_valid&&alloc_ready, write the entry at tail (valid=1, done=0) and advance tail (wraps DEPTH-1 -> 0).
//  - Writeback: at the edge, set done and capture data/addr for each wb port.
//    - Ignored when the entry is not valid or wb_idx targets a squashed slot.
//    - Same index on two ports: lower port number wins.
//  - Commit: at each edge, scan k=0..COMMIT_W-1 from head; retire the entry if valid&&done (done state as of before this edge).
//    - Stop at the first entry that is not done.
//    - At most one store per cycle; a store retires only if mem_ready=1, otherwise retirement stops at it.
//    - Retired entries go out on commit_* in the next cycle; head and count update the same edge.
//    - Alloc-to-commit minimum latency: alloc@N, wb@N+1, commit_valid high during N+2.
//  - Squash: squash_now = any wb port writes a valid branch entry with data[0]=1 (combinational).
//    - If several branches are taken, the oldest by (idx-head) mod DEPTH wins.
//    - Entries strictly younger than the branch are invalidated; tail = branch+1; count recomputed.
//    - The branch itself stays and commits normally; redirect_valid/redirect_pc are registered.
//    - An alloc request in the squash cycle is refused (alloc_ready=0).
//    - Commits older than the branch in the same cycle proceed.
//  - Full: alloc_ready=0 even if a commit frees a slot at that edge (no lookahead). Empty: commit_valid=0.
//  - A not-taken branch retires with commit_valid=1, commit_to_mem=0, and commit_rdest forced to 0 (no regfile write).
// CONFIGURATION
//  ROB_STATS_EN defined:
//    - Adds outputs stat_commits[31:0] and stat_flushes[31:0], both wrapping counters cleared by reset.
//    - stat_commits += number of entries retired per edge; stat_flushes += 1 per squash.
//  ROB_STATS_EN undefined: no counters and no stat_* ports.
// TESTING (DEPTH=4, WB_PORTS=2, COMMIT_W=2)
//  - Reset: hold reset_n=0 over 2 edges with alloc_valid=1 -> alloc_ready=1 after release; commit_valid=0, redirect_valid=0, alloc_idx=0.
//  - Fill: 4 allocs with no wb -> idx 0,1,2,3; 5th cycle alloc_ready=0.
//    Then wb idx0 and idx1 (data 0xA, 0xB) -> next edge commit_valid=2'b11, data 0xA/0xB; alloc_ready=1 the cycle after.
//  - Out-of-order wb: wb idx1 then idx0 -> no commit until idx0 done; then both retire together, in order.
//  - Stores: entries 0,1 both stores done, mem_ready=1 -> only idx0 retires that cycle, idx1 the next.
//    With mem_ready=0 neither retires.
//  - Squash: alloc 0..3, entry1 a branch; wb idx1 data=1 addr=0x40 on port1 and idx3 data=1 on port0 -> oldest (idx1) wins.
//    Response: redirect_pc=0x40; tail=2; later wb to idx2 ignored; next alloc_idx=2.
//  - Wrap and conflict: drive head/tail through 0 over 10 allocs; two ports write idx2 (0x5, 0x9) -> commit_data 0x5.

Source files
------------

// File: rtl/rob_multi_commit.sv
// rob_multi_commit
//   Reorder buffer with in-order commit. Dispatch allocates one entry per
//   cycle at the tail. WB_PORTS execution ports write results back by index.
//   Up to COMMIT_W completed entries retire per cycle from the head.
//   A taken branch squashes every younger entry and raises a one-cycle PC
//   redirect.
//
// Ports
//   clk, reset_n                    clock; synchronous active-low reset
//   alloc_valid/ready/rdest/to_mem/branch, alloc_idx
//                                   dispatch handshake; alloc_idx is the tail
//   wb_valid/idx/data/addr          flattened per-port writeback; for a branch,
//                                   data[0] = taken and addr = target
//   commit_valid/to_mem/rdest/data/addr
//                                   registered retire slots; slot 0 is oldest
//   mem_ready                       the memory stage accepts a store this cycle
//   redirect_valid, redirect_pc     registered taken-branch redirect
//
// Optional feature: define ROB_STATS_EN to add the stat_commits and
// stat_flushes counters, which are exposed as extra output ports.
module rob_multi_commit #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = 4,
  parameter int WORD_SIZE = 32,
  parameter int REG_INDEX = 5,
  parameter int WB_PORTS  = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [REG_INDEX-1:0]          alloc_rdest,
  input  logic                          alloc_to_mem,
  input  logic                          alloc_branch,
  output logic [IDX_W-1:0]              alloc_idx,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]     wb_idx,
  input  logic [WB_PORTS*WORD_SIZE-1:0] wb_data,
  input  logic [WB_PORTS*WORD_SIZE-1:0] wb_addr,
  output logic [COMMIT_W-1:0]           commit_valid,
  output logic [COMMIT_W-1:0]           commit_to_mem,
  output logic [COMMIT_W*REG_INDEX-1:0] commit_rdest,
  output logic [COMMIT_W*WORD_SIZE-1:0] commit_data,
  output logic [COMMIT_W*WORD_SIZE-1:0] commit_addr,
  input  logic                          mem_ready,
  output logic                          redirect_valid,
  output logic [WORD_SIZE-1:0]          redirect_pc
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]                   stat_commits,
  output logic [31:0]                   stat_flushes
`endif
);
  localparam int CNT_W = IDX_W + 1;

  // entry storage
  logic [DEPTH-1:0]                valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0]                to_mem_q, to_mem_d, branch_q, branch_d;
  logic [DEPTH-1:0][REG_INDEX-1:0] rdest_q, rdest_d;
  logic [DEPTH-1:0][WORD_SIZE-1:0] data_q, data_d, addr_q, addr_d;
  logic [IDX_W-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                count_q, count_d;

  // registered outputs
  logic [COMMIT_W-1:0]                cvalid_q, cvalid_d, cmem_q, cmem_d;
  logic [COMMIT_W-1:0][REG_INDEX-1:0] crdest_q, crdest_d;
  logic [COMMIT_W-1:0][WORD_SIZE-1:0] cdata_q, cdata_d, caddr_q, caddr_d;
  logic                               redir_q, redir_d;
  logic [WORD_SIZE-1:0]               rpc_q, rpc_d;

  // per-port views of the flattened writeback buses
  logic [WB_PORTS-1:0][IDX_W-1:0]     wb_i, wb_off;
  logic [WB_PORTS-1:0][WORD_SIZE-1:0] wb_dat, wb_adr;
  logic [WB_PORTS-1:0]                wb_eff;
  assign wb_i   = wb_idx;
  assign wb_dat = wb_data;
  assign wb_adr = wb_addr;

  // age of each entry relative to the head; commit slot indices
  logic [DEPTH-1:0][IDX_W-1:0]    ent_off;
  logic [COMMIT_W-1:0][IDX_W-1:0] slot_idx;
  for (genvar g = 0; g < DEPTH; g++) begin : g_off
    assign ent_off[g] = IDX_W'(g) - head_q;
  end
  for (genvar g = 0; g < COMMIT_W; g++) begin : g_slot
    assign slot_idx[g] = head_q + IDX_W'(g);
  end

  logic                 squash_now;
  logic [IDX_W-1:0]     br_idx, br_off;
  logic [WORD_SIZE-1:0] br_pc;
  logic [DEPTH-1:0]     kill;
  logic [COMMIT_W-1:0]  ret;
  logic [CNT_W-1:0]     n_ret;
  logic                 store_used, stop, alloc_fire;

  assign alloc_ready = (count_q < CNT_W'(DEPTH)) && !squash_now;
  assign alloc_idx   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // A port is effective when it targets a live entry and no lower-numbered
  // port hits the same index in this cycle.
  always_comb begin
    wb_eff = '0;
    wb_off = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_off[p] = wb_i[p] - head_q;
      wb_eff[p] = wb_valid[p] && valid_q[wb_i[p]];
      for (int r = 0; r < p; r++)
        if (wb_valid[r] && (wb_i[r] == wb_i[p])) wb_eff[p] = 1'b0;
    end
  end

  // Oldest taken branch wins; everything strictly younger is killed.
  always_comb begin
    squash_now = 1'b0;
    br_idx     = '0;
    br_off     = '0;
    br_pc      = '0;
    kill       = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_eff[p] && branch_q[wb_i[p]] && wb_dat[p][0] &&
          (!squash_now || (wb_off[p] < br_off))) begin
        squash_now = 1'b1;
        br_idx     = wb_i[p];
        br_off     = wb_off[p];
        br_pc      = wb_adr[p];
      end
    end
    for (int i = 0; i < DEPTH; i++)
      kill[i] = squash_now && (ent_off[i] > br_off);
  end

  // In-order retire scan using done state from before this edge.
  always_comb begin
    ret        = '0;
    n_ret      = '0;
    store_used = 1'b0;
    stop       = 1'b0;
    cvalid_d   = '0;
    cmem_d     = '0;
    crdest_d   = '0;
    cdata_d    = '0;
    caddr_d    = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (!stop && valid_q[slot_idx[k]] && done_q[slot_idx[k]] &&
          !kill[slot_idx[k]] &&
          (!to_mem_q[slot_idx[k]] || (mem_ready && !store_used))) begin
        ret[k]      = 1'b1;
        n_ret       = n_ret + CNT_W'(1);
        store_used  = store_used | to_mem_q[slot_idx[k]];
        cvalid_d[k] = 1'b1;
        cmem_d[k]   = to_mem_q[slot_idx[k]];
        // branches never write the register file
        crdest_d[k] = branch_q[slot_idx[k]] ? '0 : rdest_q[slot_idx[k]];
        cdata_d[k]  = data_q[slot_idx[k]];
        caddr_d[k]  = addr_q[slot_idx[k]];
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    to_mem_d = to_mem_q;
    branch_d = branch_q;
    rdest_d  = rdest_q;
    data_d   = data_q;
    addr_d   = addr_q;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_eff[p] && !kill[wb_i[p]]) begin
        done_d[wb_i[p]] = 1'b1;
        data_d[wb_i[p]] = wb_dat[p];
        addr_d[wb_i[p]] = wb_adr[p];
      end
    end
    valid_d = valid_d & ~kill;
    done_d  = done_d & ~kill;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (ret[k]) begin
        valid_d[slot_idx[k]] = 1'b0;
        done_d[slot_idx[k]]  = 1'b0;
      end
    end
    // alloc never fires on a squash or when full, so the tail slot is free
    if (alloc_fire) begin
      valid_d[tail_q]  = 1'b1;
      done_d[tail_q]   = 1'b0;
      to_mem_d[tail_q] = alloc_to_mem;
      branch_d[tail_q] = alloc_branch;
      rdest_d[tail_q]  = alloc_rdest;
    end
    head_d = head_q + n_ret[IDX_W-1:0];
    if (squash_now) begin
      tail_d  = br_idx + IDX_W'(1);
      count_d = CNT_W'(br_off) + CNT_W'(1) - n_ret;
    end else begin
      tail_d  = tail_q + IDX_W'(alloc_fire);
      count_d = count_q + CNT_W'(alloc_fire) - n_ret;
    end
    redir_d = squash_now;
    rpc_d   = br_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= '0;
      done_q   <= '0;
      to_mem_q <= '0;
      branch_q <= '0;
      rdest_q  <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cvalid_q <= '0;
      cmem_q   <= '0;
      crdest_q <= '0;
      cdata_q  <= '0;
      caddr_q  <= '0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      to_mem_q <= to_mem_d;
      branch_q <= branch_d;
      rdest_q  <= rdest_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cvalid_q <= cvalid_d;
      cmem_q   <= cmem_d;
      crdest_q <= crdest_d;
      cdata_q  <= cdata_d;
      caddr_q  <= caddr_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
    end
  end

  assign commit_valid   = cvalid_q;
  assign commit_to_mem  = cmem_q;
  assign commit_rdest   = crdest_q;
  assign commit_data    = cdata_q;
  assign commit_addr    = caddr_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = rpc_q;

`ifdef ROB_STATS_EN
  logic [31:0] stat_commits_q, stat_commits_d, stat_flushes_q, stat_flushes_d;

  always_comb begin
    stat_commits_d = stat_commits_q + 32'(n_ret);
    stat_flushes_d = stat_flushes_q + 32'(squash_now);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_commits_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_commits_q <= stat_commits_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  assign stat_commits = stat_commits_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule
